// File: rtl/encoder_4x2.sv
// rtl/encoder_4x2.sv - registered 4-to-2 priority encoder with enable, valid and multi-hot flags
module encoder_4x2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] i,
  output logic [1:0] y,
  output logic       valid,
  output logic       multi
);

  logic [1:0] y_d, y_q;
  logic       valid_d, valid_q;
  logic       multi_d, multi_q;

  // Next-state encode: highest set bit wins; idle values whenever en is low
  always_comb begin
    y_d     = 2'b00;
    valid_d = 1'b0;
    multi_d = 1'b0;
    if (en) begin
      if (i[3]) begin
        y_d = 2'b11;
      end else if (i[2]) begin
        y_d = 2'b10;
      end else if (i[1]) begin
        y_d = 2'b01;
      end else begin
        y_d = 2'b00;
      end
      valid_d = |i;
      // Two or more bits set means some pair of bits is set together
      multi_d = (i[3] & (i[2] | i[1] | i[0])) |
                (i[2] & (i[1] | i[0]))        |
                (i[1] & i[0]);
    end
  end

  // Output registers; reset clears them immediately, independent of clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= 2'b00;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
    end
  end

  assign y     = y_q;
  assign valid = valid_q;
  assign multi = multi_q;

endmodule

// File: tb/tb_encoder_4x2.sv
// tb/tb_encoder_4x2.sv - self-checking bench for encoder_4x2 with behavioural model
module tb_encoder_4x2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [3:0] i = 4'b0000;
  logic [1:0] y;
  logic       valid;
  logic       multi;

  int checks = 0;
  int passes = 0;
  bit run_cmp = 1'b0;

  logic [3:0] exp_q;  // {y, valid, multi} the DUT must show

  encoder_4x2 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .i     (i),
    .y     (y),
    .valid (valid),
    .multi (multi)
  );

  always #5 clk = ~clk;

  // Reference: index of highest set bit found by scanning, popcount by counting
  function automatic logic [3:0] model(input logic e, input logic [3:0] v);
    int hi;
    int cnt;
    logic [1:0] ry;
    hi  = -1;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (v[k]) begin
        hi  = k;
        cnt = cnt + 1;
      end
    end
    if (!e) return 4'b0000;
    ry = (hi >= 0) ? 2'(hi) : 2'b00;
    return {ry, (hi >= 0), (cnt >= 2)};
  endfunction

  // Expected outputs: one-cycle-delayed model, cleared by reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_q <= 4'b0000;
    else        exp_q <= model(en, i);
  end

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got y=%b valid=%b multi=%b, expected y=%b valid=%b multi=%b",
                  name, got[3:2], got[1], got[0], want[3:2], want[1], want[0]);
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (run_cmp) check("cycle", {y, valid, multi}, exp_q);
  end

  task automatic step(input logic e, input logic [3:0] v);
    @(posedge clk);
    #1;
    en = e;
    i  = v;
  endtask

  // Apply one vector, then check the registered result against a literal
  task automatic lit(input string name, input logic e, input logic [3:0] v, input logic [3:0] want);
    step(e, v);
    @(posedge clk);
    @(negedge clk);
    check(name, {y, valid, multi}, want);
  endtask

  logic [3:0] sweep_exp [4];

  initial begin
    sweep_exp[0] = 4'b0010;
    sweep_exp[1] = 4'b0110;
    sweep_exp[2] = 4'b1010;
    sweep_exp[3] = 4'b1110;

    // Reset held with all requests asserted and clk running
    #2;
    rst_n = 1'b0;
    en    = 1'b1;
    i     = 4'b1111;
    run_cmp = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("reset_hold", {y, valid, multi}, 4'b0000);
    end
    rst_n = 1'b1;

    // One-hot sweep, back to back
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 4'(1 << k));
      @(negedge clk);
      if (k > 0) check("onehot", {y, valid, multi}, sweep_exp[k-1]);
    end
    @(posedge clk);
    @(negedge clk);
    check("onehot_last", {y, valid, multi}, sweep_exp[3]);

    // Enable gating, zero input, multi-hot priority
    lit("en_low",    1'b0, 4'b0010, 4'b0000);
    lit("en_high",   1'b1, 4'b0010, 4'b0110);
    lit("zero",      1'b1, 4'b0000, 4'b0000);
    lit("multi1011", 1'b1, 4'b1011, 4'b1111);
    lit("multi0110", 1'b1, 4'b0110, 4'b1011);
    lit("multi0011", 1'b1, 4'b0011, 4'b0111);
    lit("en_low_all", 1'b0, 4'b1111, 4'b0000);

    // Asynchronous reset mid-cycle clears without a clk edge
    step(1'b1, 4'b1111);
    @(posedge clk);
    #3;
    check("pre_async", {y, valid, multi}, 4'b1111);
    rst_n = 1'b0;
    #1;
    check("async_clear", {y, valid, multi}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive 32 vectors back to back
    for (int e = 0; e < 2; e++) begin
      for (int v = 0; v < 16; v++) begin
        step(e[0], 4'(v));
      end
    end

    // Randomized stream with occasional mid-cycle resets
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 49) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("rand_async", {y, valid, multi}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    @(posedge clk);
    @(negedge clk);
    run_cmp = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/encoder_4x2.md
# encoder_4x2

Registered 4-to-2 priority encoder with enable. It converts a 4-bit request vector into the 2-bit index of the highest set bit and flags whether the index is valid and whether more than one request was set. It sits at the boundary between request-generating logic and downstream selection/muxing logic, and presents clean registered outputs to that logic.

## Interface
- No parameters; widths are fixed at 4 inputs and 2 output bits.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, asynchronous assert, active-low; clears all registers.
- en  input  1  encode enable; when low, outputs are forced to their idle values on the next edge.
- i  input  4  request vector; i[3] has highest priority, i[0] lowest.
- y  output  2  registered binary index of the highest-priority set bit of i.
- valid  output  1  registered; high when en was high and at least one bit of i was set.
- multi  output  1  registered; high when en was high and two or more bits of i were set.

## Operation
- Each rising clk edge samples en and i and loads y, valid and multi together.
- en = 0: y <= 2'b00, valid <= 0, multi <= 0, whatever the value of i.
- en = 1, i = 4'b0000: y <= 2'b00, valid <= 0, multi <= 0.
- en = 1, one or more bits of i set: y <= index of the highest set bit, valid <= 1.
  - i[3] set: y = 2'b11.
  - else i[2] set: y = 2'b10.
  - else i[1] set: y = 2'b01.
  - else i[0] set: y = 2'b00.
- multi <= 1 when en = 1 and the population count of i is at least 2; otherwise 0.
- When more than one bit is set, the result follows the priority rule and no error is raised. multi is informational only.
- y = 2'b00 is ambiguous: it means either "i[0] only" or "nothing valid". Consumers must qualify y with valid.
- Inputs are assumed synchronous to clk. The block contains no input synchronizers.

## Timing
- Latency is exactly 1 clk cycle from sampled en/i to y/valid/multi.
- Throughput is one new encode per cycle. There is no handshake and no backpressure.
- Outputs hold their values between edges and change only on a rising clk edge or on reset assertion.
- Reset values: y = 2'b00, valid = 0, multi = 0.
- rst_n falling drives all outputs to their reset values immediately, with no dependence on clk.
- While rst_n is low, clk edges have no effect.
- After rst_n deasserts, the first rising clk edge samples inputs normally.
- Reset asserted mid-stream discards the encode in progress. No state is retained, because the block holds no state beyond the output registers.
- Simultaneous en fall and i change: only the values present at the sampling edge matter, so en = 0 wins.
- There are no combinational paths from inputs to outputs.

## Test plan
- Reset: hold rst_n = 0 with en = 1 and i = 4'b1111, while toggling clk. Required: y = 00, valid = 0, multi = 0 throughout. Then assert rst_n asynchronously mid-cycle and confirm the outputs clear without waiting for a clk edge.
- One-hot sweep, en = 1, i = 0001, 0010, 0100, 1000 on consecutive cycles. Required, one cycle later each: y = 00, 01, 10, 11 with valid = 1 and multi = 0.
- Enable gating: en = 0 with i = 4'b0010. Required: y = 00, valid = 0, multi = 0. Then en = 1 with the same i. Required: y = 01, valid = 1.
- Zero input: en = 1, i = 4'b0000. Required: y = 00, valid = 0, multi = 0.
- Multi-hot priority cases, all with en = 1:
  - i = 4'b1011 -> y = 11, valid = 1, multi = 1.
  - i = 4'b0110 -> y = 10, multi = 1.
  - i = 4'b0011 -> y = 01, multi = 1.
- Exhaustive check: all 16 values of i with en = 0 and en = 1 (32 vectors), back-to-back. Each registered result must match the priority/popcount rules exactly one cycle after it is applied.
